// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, sub-word stores done as read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses report an error instead of being aligned down.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_legal;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_err;
  logic [31:0] w_eff_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Request decode, evaluated while idle on the raw request inputs
  always_comb begin
    w_legal = req_we ? (req_funct3 inside {3'd0, 3'd1, 3'd2})
                     : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    w_eff_addr = req_addr;
    w_misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    w_eff_addr = req_addr;
    w_misalign = 1'b0;
    case (req_funct3[1:0])
      2'd1:    w_eff_addr[0]   = 1'b0;
      2'd2:    w_eff_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif
    w_range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    w_err       = !w_legal || w_misalign || w_range_err;
  end

  // Load lane extraction from the live read data, and RMW merge from the captured word
  always_comb begin
    w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = mem_read_data;
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
    w_merge = r_word;
    case (r_funct3[1:0])
      2'd0:    w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'd1:    w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                                   w_next = S_RESP;
          else if (req_we && (req_funct3[1:0] == 2'd2)) w_next = S_WR;
          else                                         w_next = S_RD;
        end
      end
      S_RD: begin
        mem_read    = 1'b1;
        mem_address = {r_addr[31:2], 2'b00};
        w_next      = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        mem_write      = 1'b1;
        mem_address    = {r_addr[31:2], 2'b00};
        mem_write_data = w_merge;
        w_next         = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= req_funct3;
          r_addr   <= w_eff_addr;
          r_wdata  <= req_wdata;
          r_err    <= w_err;
          r_rdata  <= '0;
        end
        S_RD: begin
          r_word <= mem_read_data;
          if (!r_we) r_rdata <= w_load;
        end
        S_RESP: if (resp_ready) begin
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases plus randomized
// requests scored against a byte-arithmetic memory model.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        tb_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_wd;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_address[11:2]] <= mem_write_data;
    else if (tb_we) mem[tb_idx] <= tb_wd;
  end

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    tb_we  = 1'b1;
    tb_idx = idx[9:0];
    tb_wd  = val;
    @(posedge clk);
    #1 tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference: byte-addressed memory semantics computed directly from the ISA rules
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                           output int lat, output int nrd, output int nwr, output logic [31:0] waddr);
    int unsigned nbytes, off, idx;
    logic [31:0] a, mask, word;
    logic legal, misal;
    legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes = 32'd1 << f3[1:0];
    a      = addr;
    misal  = (a % nbytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = !legal || misal;
`else
    err = !legal;
    if (legal) a = a - (a % nbytes);
`endif
    if ((a / 4) >= MEM_WORDS) err = 1'b1;
    rdata = '0; nrd = 0; nwr = 0; lat = 1; waddr = '0;
    if (err) return;
    waddr = a - (a % 4);
    idx   = a / 4;
    off   = a % 4;
    word  = ref_mem[idx];
    mask  = (nbytes == 1) ? 32'hFF : (nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!we) begin
      rdata = (word >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && (rdata & ((mask >> 1) + 1)) != 0) rdata = rdata | ~mask;
      nrd = 1; lat = 2;
    end else if (nbytes == 4) begin
      ref_mem[idx] = wdata; nwr = 1; lat = 2;
    end else begin
      ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      nrd = 1; nwr = 1; lat = 3;
    end
  endtask

  // Drives one request and records what the DUT did; hold = cycles to stall resp_ready
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] obs_addr,
                         output logic [31:0] obs_wd, output logic proto_ok);
    bit seen;
    proto_ok = 1'b1; nrd = 0; nwr = 0; obs_addr = '0; obs_wd = '0; seen = 0;
    @(negedge clk);
    if (!req_ready) proto_ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (req_ready || (mem_read && mem_write) || mem_address[1:0] != 2'b00) proto_ok = 1'b0;
      if (mem_read || mem_write) begin
        if (seen && mem_address != obs_addr) proto_ok = 1'b0;
        obs_addr = mem_address; seen = 1;
      end else if (mem_address != 0 || mem_write_data != 0) proto_ok = 1'b0;
      if (mem_write) obs_wd = mem_write_data;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid || resp_rdata !== rdata || resp_err !== err || req_ready ||
          mem_read || mem_write || mem_address != 0 || mem_write_data != 0) proto_ok = 1'b0;
      @(negedge clk);
    end
    if (!resp_valid || mem_read || mem_write) proto_ok = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!req_ready || resp_valid) proto_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, wd;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
    preload(32'h10, 32'h8077_F0A5);
    preload(32'h40, 32'h1122_3344);
    preload(32'h80, 32'h5566_7788);
    preload(32'h1,  32'h0BAD_F00D);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_write_data}
        !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_errs++;
      $display("FAIL reset_outputs: ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wd=%h, required ready=1 others 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_address, mem_write_data);
    end
    rst_n = 1'b1;
    rd = '0; wd = '0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [5] = '{32'h40, 32'h40, 32'h42, 32'h42, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_8077, 32'h0000_8077, 32'h8077_F0A5};
    logic [31:0] rd, oa, ow; logic er, pk; int lat, nr, nw;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, f3s[i], adrs[i], 32'd0, 0, rd, er, lat, nr, nw, oa, ow, pk);
      n_checks++;
      if ({er, rd} !== {1'b0, exps[i]}) begin
        n_errs++;
        $display("FAIL load_data[%0d]: got err=%b rdata=%h, required err=0 rdata=%h", i, er, rd, exps[i]);
      end
      n_checks++;
      if (lat != 2 || nr != 1 || nw != 0 || oa != 32'h40 || !pk) begin
        n_errs++;
        $display("FAIL load_timing[%0d]: got lat=%0d rd=%0d wr=%0d addr=%h proto=%b, required 2 1 0 00000040 1",
                 i, lat, nr, nw, oa, pk);
      end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] rd, oa, ow, ma; logic er, pk, me; int lat, nr, nw, ml, mr, mw;
    logic [31:0] exps [2] = '{32'h11AB_3344, 32'h11AB_BEEF};
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        model_req(1'b1, 3'd0, 32'h102, 32'h0000_00AB, me, rd, ml, mr, mw, ma);
        run_req(1'b1, 3'd0, 32'h102, 32'h0000_00AB, 0, rd, er, lat, nr, nw, oa, ow, pk);
      end else begin
        model_req(1'b1, 3'd1, 32'h100, 32'h1234_BEEF, me, rd, ml, mr, mw, ma);
        run_req(1'b1, 3'd1, 32'h100, 32'h1234_BEEF, 0, rd, er, lat, nr, nw, oa, ow, pk);
      end
      n_checks++;
      if (ow !== exps[i] || mem[32'h40] !== exps[i]) begin
        n_errs++;
        $display("FAIL rmw_data[%0d]: got wdata=%h mem=%h, required %h", i, ow, mem[32'h40], exps[i]);
      end
      n_checks++;
      if (lat != 3 || nr != 1 || nw != 1 || er !== 1'b0 || rd !== 32'd0 || oa != 32'h100 || !pk) begin
        n_errs++;
        $display("FAIL rmw_timing[%0d]: got lat=%0d rd=%0d wr=%0d err=%b rdata=%h addr=%h proto=%b, required 3 1 1 0 0 00000100 1",
                 i, lat, nr, nw, er, rd, oa, pk);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, oa, ow, ma; logic er, pk, me; int lat, nr, nw, ml, mr, mw;
    model_req(1'b1, 3'd2, 32'h0, 32'hCAFE_F00D, me, rd, ml, mr, mw, ma);
    run_req(1'b1, 3'd2, 32'h0, 32'hCAFE_F00D, 5, rd, er, lat, nr, nw, oa, ow, pk);
    n_checks++;
    if (nw != 1 || nr != 0 || lat != 2 || ow !== 32'hCAFE_F00D || mem[0] !== 32'hCAFE_F00D) begin
      n_errs++;
      $display("FAIL sw_stall: got wr=%0d rd=%0d lat=%0d wdata=%h mem=%h, required 1 0 2 cafef00d cafef00d",
               nw, nr, lat, ow, mem[0]);
    end
    n_checks++;
    if (!pk || er !== 1'b0) begin
      n_errs++;
      $display("FAIL sw_stall_hold: got proto=%b err=%b, required 1 0", pk, er);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, oa, ow; logic er, pk; int lat, nr, nw;
    run_req(1'b0, 3'd2, 32'h6, 32'd0, 0, rd, er, lat, nr, nw, oa, ow, pk);
    n_checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nr != 0 || nw != 0 || !pk) begin
      n_errs++;
      $display("FAIL misalign_lw: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d proto=%b, required 1 0 1 0 0 1",
               er, rd, lat, nr, nw, pk);
    end
`else
    if (er !== 1'b0 || rd !== 32'h0BAD_F00D || lat != 2 || nr != 1 || nw != 0 || oa != 32'h4 || !pk) begin
      n_errs++;
      $display("FAIL misalign_lw: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d addr=%h proto=%b, required 0 0badf00d 2 1 0 00000004 1",
               er, rd, lat, nr, nw, oa, pk);
    end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] rd, oa, ow; logic er, pk; int lat, nr, nw;
    logic        wes  [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [3] = '{3'd3, 3'd2, 3'd4};
    logic [31:0] adrs [3] = '{32'h40, 32'h1000, 32'h40};
    for (int i = 0; i < 3; i++) begin
      run_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 0, rd, er, lat, nr, nw, oa, ow, pk);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nr != 0 || nw != 0 || !pk) begin
        n_errs++;
        $display("FAIL error_req[%0d]: got err=%b rdata=%h lat=%0d rd=%0d wr=%0d proto=%b, required 1 0 1 0 0 1",
                 i, er, rd, lat, nr, nw, pk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] q_data [$];
    logic [31:0] a, d, wa; logic [2:0] f3; logic e;
    int l, r, w, issued, got, cyc, last_acc, bad_gap;
    issued = 0; got = 0; cyc = 0; last_acc = -1; bad_gap = 0;
    resp_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_valid && q_data.size() > 0) begin
        n_checks++;
        if ({resp_err, resp_rdata} !== {1'b0, q_data[0]}) begin
          n_errs++;
          $display("FAIL b2b_data[%0d]: got err=%b rdata=%h, required err=0 rdata=%h", got, resp_err, resp_rdata, q_data[0]);
        end
        void'(q_data.pop_front());
        got++;
      end
      if (req_ready && issued < 8) begin
        f3 = ld_f3[$urandom_range(0, 4)];
        a  = $urandom_range(0, 4095);
        a  = a & ~((32'd1 << f3[1:0]) - 32'd1);
        model_req(1'b0, f3, a, 32'd0, e, d, l, r, w, wa);
        q_data.push_back(d);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a;
        if (last_acc >= 0 && cyc - last_acc != 3) bad_gap++;
        last_acc = cyc;
        issued++;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (got != 8 || bad_gap != 0) begin
      n_errs++;
      $display("FAIL b2b_throughput: got responses=%0d bad_gaps=%0d, required 8 0", got, bad_gap);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, oa, ow, a, wd, ed, ea; logic er, pk, ee, we; logic [2:0] f3;
    int lat, nr, nw, el, er_n, ew, sel;
    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = (sel < 8) ? 32'($urandom_range(0, 4095)) : (sel == 8) ? 32'($urandom_range(4096, 8191)) : $urandom;
      wd  = $urandom;
      model_req(we, f3, a, wd, ee, ed, el, er_n, ew, ea);
      run_req(we, f3, a, wd, $urandom_range(0, 2), rd, er, lat, nr, nw, oa, ow, pk);
      n_checks++;
      if ({er, rd} !== {ee, ed}) begin
        n_errs++;
        $display("FAIL rand_data[%0d] we=%b f3=%0d addr=%h: got err=%b rdata=%h, required err=%b rdata=%h",
                 i, we, f3, a, er, rd, ee, ed);
      end
      n_checks++;
      if (lat != el || nr != er_n || nw != ew || oa != ea || !pk) begin
        n_errs++;
        $display("FAIL rand_timing[%0d] we=%b f3=%0d addr=%h: got lat=%0d rd=%0d wr=%0d addr=%h proto=%b, required %0d %0d %0d %h 1",
                 i, we, f3, a, lat, nr, nw, oa, pk, el, er_n, ew, ea);
      end
      if (ew != 0) begin
        n_checks++;
        if (mem[ea[11:2]] !== ref_mem[ea[11:2]]) begin
          n_errs++;
          $display("FAIL rand_mem[%0d] word %h: got %h, required %h", i, ea, mem[ea[11:2]], ref_mem[ea[11:2]]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    nwr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h202; req_wdata = 32'h0000_0099;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_errs++;
      $display("FAIL midreset_rd_cycle: got mem_read=%b, required 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, mem_address, req_ready, resp_valid} !== {1'b0, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      n_errs++;
      $display("FAIL midreset_abort: got rd=%b wr=%b addr=%h ready=%b rv=%b, required 0 0 0 1 0",
               mem_read, mem_write, mem_address, req_ready, resp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nwr += int'(mem_write) + int'(mem_read) + int'(resp_valid);
    end
    n_checks++;
    if (nwr != 0 || mem[32'h80] !== 32'h5566_7788) begin
      n_errs++;
      $display("FAIL midreset_no_write: got activity=%0d mem=%h, required 0 55667788", nwr, mem[32'h80]);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; tb_we = 1'b0; tb_idx = '0; tb_wd = '0;
    test_reset();
    test_loads();
    test_rmw();
    test_backpressure();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
